// File: rtl/stream_byte_feeder_if.sv
// Handshake/data bundle between the stream side, the byte feeder and the consuming engine.
// The feeder binds to the slave modport; the environment (producer + consumer) to master.
interface stream_byte_feeder_if #(
  parameter int NUM_BYTES_INPUT_WIDTH  = 8,
  parameter int NUM_BYTES_OUTPUT_WIDTH = 16,
  parameter int FIFO_DEPTH             = 64
);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int CONS_W = $clog2(NUM_BYTES_OUTPUT_WIDTH) + 1;

  logic [NUM_BYTES_INPUT_WIDTH-1:0][7:0]  dataIn;
  logic                                   dataInValid;
  logic                                   dataInLast;
  logic                                   dataInReady;
  logic [NUM_BYTES_OUTPUT_WIDTH-1:0][7:0] dataOut;
  logic [CNT_W-1:0]                       dataOutBytesValid;
  logic [CONS_W-1:0]                      dataOutConsume;
  logic                                   endOfStream;

  modport master (
    output dataIn, dataInValid, dataInLast, dataOutConsume,
    input  dataInReady, dataOut, dataOutBytesValid, endOfStream
  );

  modport slave (
    input  dataIn, dataInValid, dataInLast, dataOutConsume,
    output dataInReady, dataOut, dataOutBytesValid, endOfStream
  );
endinterface

// File: rtl/stream_byte_feeder.sv
// Circular byte buffer: fixed-width beat writes, variable-width consume from a byte window.
// Optional over-consume clamp and sticky error flag: define STREAM_BYTE_FEEDER_CONSUME_CHECK_EN.
module stream_byte_feeder #(
  parameter int NUM_BYTES_INPUT_WIDTH  = 8,
  parameter int NUM_BYTES_OUTPUT_WIDTH = 16,
  parameter int FIFO_DEPTH             = 64
) (
  input  logic                clk,
  input  logic                resetn,
  stream_byte_feeder_if.slave bus
`ifdef STREAM_BYTE_FEEDER_CONSUME_CHECK_EN
  ,
  output logic                consumeError
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] IN_CNT    = CNT_W'(NUM_BYTES_INPUT_WIDTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] IN_PTR    = PTR_W'(NUM_BYTES_INPUT_WIDTH);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, EOS} state_t;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic [CNT_W-1:0] consume_req;
  logic [CNT_W-1:0] consume_eff;
  logic [CNT_W-1:0] free_bytes;
  logic             in_ready;
  logic             accept;
  state_t           state;
  state_t           state_next;

  assign consume_req = CNT_W'(bus.dataOutConsume);

`ifdef STREAM_BYTE_FEEDER_CONSUME_CHECK_EN
  function automatic logic [CNT_W-1:0] clamp_consume(input logic [CNT_W-1:0] req,
                                                     input logic [CNT_W-1:0] avail);
    return (req > avail) ? avail : req;
  endfunction

  assign consume_eff = clamp_consume(consume_req, count);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      consumeError <= 1'b0;
    end else if (consume_req > count) begin
      consumeError <= 1'b1;
    end
  end
`else
  assign consume_eff = consume_req;
`endif

  // Readiness looks only at the current fill level; a same-cycle consume earns no credit.
  assign free_bytes = DEPTH_CNT - count;
  assign in_ready   = resetn && ((state == IDLE) || (state == STREAM)) && (free_bytes >= IN_CNT);
  assign accept     = bus.dataInValid && in_ready;
  assign count_next = count + (accept ? IN_CNT : '0) - consume_eff;

  // ---- control registers ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      state  <= IDLE;
    end else begin
      rd_ptr <= rd_ptr + consume_eff[PTR_W-1:0];
      if (accept) begin
        wr_ptr <= wr_ptr + IN_PTR;
      end
      count  <= count_next;
      state  <= state_next;
    end
  end

  // ---- byte storage (data only, never reset) ----
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < NUM_BYTES_INPUT_WIDTH; i++) begin
        mem[wr_ptr + PTR_W'(i)] <= bus.dataIn[i];
      end
    end
  end

  // ---- output window: lanes beyond the fill level are forced to zero ----
  always_comb begin
    for (int i = 0; i < NUM_BYTES_OUTPUT_WIDTH; i++) begin
      bus.dataOut[i] = 8'h00;
      if (CNT_W'(i) < count) begin
        bus.dataOut[i] = mem[rd_ptr + PTR_W'(i)];
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = bus.dataInLast ? DRAIN : STREAM;
        end
      end
      STREAM: begin
        if (accept && bus.dataInLast) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (count_next == '0) begin
          state_next = EOS;
        end
      end
      EOS: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.dataInReady       = in_ready;
  assign bus.dataOutBytesValid = count;
  assign bus.endOfStream       = (state == EOS);

endmodule

// File: doc/stream_byte_feeder.md
Name: stream_byte_feeder

Overview:
Read-side counterpart of the compressor's return path. Accepts fixed-width input beats from the DMA/AXI-stream side and presents a byte-aligned window plus a byte count to a downstream engine. The engine consumes a variable number of bytes per cycle, so the block is a circular byte buffer with a fixed-width write port and a variable-width read port. It sits between the stream slave interface and the compressor/decompressor datapath, and it signals end of stream once the final beat has fully drained.

Parameters:
NUM_BYTES_INPUT_WIDTH, 8, bytes per input beat
NUM_BYTES_OUTPUT_WIDTH, 16, bytes visible in the output window
FIFO_DEPTH, 64, buffer bytes; must be a power of two and at least NUM_BYTES_INPUT_WIDTH+NUM_BYTES_OUTPUT_WIDTH

Ports:
clk  in  1  single clock; all logic on posedge
resetn  in  1  asynchronous, active-low reset
dataIn  in  [NUM_BYTES_INPUT_WIDTH-1:0][7:0]  input beat; byte 0 is first in stream order
dataInValid  in  1  beat valid
dataInLast  in  1  final beat of stream; qualified by dataInValid
dataInReady  out  1  block accepts the beat this cycle
dataOut  out  [NUM_BYTES_OUTPUT_WIDTH-1:0][7:0]  window; byte i is buffer[readPtr+i]
dataOutBytesValid  out  $clog2(FIFO_DEPTH)+1  bytes held; may exceed NUM_BYTES_OUTPUT_WIDTH
dataOutConsume  in  $clog2(NUM_BYTES_OUTPUT_WIDTH)+1  bytes consumer removes this cycle, 0..NUM_BYTES_OUTPUT_WIDTH
endOfStream  out  1  one-cycle pulse after the last byte is consumed

Behaviour:
- Reset (resetn=0, asynchronous): readPtr=0, writePtr=0, count=0, state=IDLE, endOfStream=0, dataInReady=0, dataOut all zero, dataOutBytesValid=0.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally modulo FIFO_DEPTH. count is $clog2(FIFO_DEPTH)+1 bits so it can represent FIFO_DEPTH exactly.
- dataInReady (combinational) = resetn && state in {IDLE,STREAM} && (FIFO_DEPTH-count) >= NUM_BYTES_INPUT_WIDTH. It uses the current count only and takes no credit for a same-cycle consume.
- Accept = dataInValid && dataInReady. On accept, bytes are written at writePtr+i and writePtr advances by NUM_BYTES_INPUT_WIDTH.
- Consume: readPtr advances by dataOutConsume. Buffer contents are not cleared.
- count_next = count + (accept ? NUM_BYTES_INPUT_WIDTH : 0) - dataOutConsume. A simultaneous accept and consume both take effect in the same cycle.
- dataOut is combinational from the buffer at readPtr. Byte lanes i >= count read as 0x00. Both dataOut and dataOutBytesValid reflect register state, so there is zero latency from a register update to the output.
- A write becomes visible on dataOut the cycle after it is accepted. There is no bypass.
- Consume > count is a protocol violation; see Optional Feature.
- FSM:
  IDLE: go to STREAM on an accept without last; go to DRAIN on an accept with last.
  STREAM: go to DRAIN on an accept with last.
  DRAIN: dataInReady=0; go to EOS when count_next==0.
  EOS: endOfStream=1 for exactly one cycle; go to IDLE.
- Zero-length stream cases: a last beat is always 8 bytes, so DRAIN is never entered with count 0 before the accept.
- Reset asserted mid-stream discards all buffered data and any pending end of stream. No endOfStream pulse is generated.

Optional Feature:
STREAM_BYTE_FEEDER_CONSUME_CHECK_EN
- Defined: dataOutConsume is clamped to min(dataOutConsume, count) before updating readPtr and count. Adds output port consumeError (1 bit). It is sticky high from the cycle after any over-consume and cleared only by reset (reset value 0).
- Undefined: no clamp and no port. An over-consume leaves count and readPtr undefined, which is a bench assertion failure.

Test Plan:
- Reset: hold resetn=0 with dataInValid=1 -> dataInReady=0, dataOutBytesValid=0, dataOut=0, endOfStream=0. Release -> dataInReady=1 next evaluation.
- Fill: push beats 00..07 then 08..0F, consume=0 -> dataOutBytesValid 8 then 16, dataOut[0..15]=00..0F, upper lanes zero when count=8.
- Mixed: from count=16, consume 3 -> dataOut[0]=03, count 13. Then accept a beat and consume 5 in the same cycle -> count 16, dataOut[0]=08.
- Full and wrap: push 8 beats, no consume -> count 64, dataInReady=0. Consume 16 per cycle with continuous push over 40 beats -> byte sequence on dataOut continuous across pointer wrap, no gaps or duplicates.
- End of stream: accept a beat with dataInLast=1 (count 8) -> dataInReady=0 in DRAIN. Consume 5 then 3 -> endOfStream=1 for one cycle after count reaches 0, then dataInReady=1 in IDLE.
- With STREAM_BYTE_FEEDER_CONSUME_CHECK_EN: at count=8, consume 12 -> count 0, consumeError=1 next cycle and remaining 1 until resetn=0.
